// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_WAIT_W        = 4;
  localparam int DMEM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane write enables; synchronous write and read ports.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable access delay.
// Optional DMEM_PERF_CNT_EN adds read/write access counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t            state, state_nx;
  logic [DMEM_WAIT_W-1:0] cnt;
  logic                   lat_we;
  logic [29:0]            lat_idx;
  logic [31:0]            lat_wdata;
  logic [3:0]             lat_be;

  logic        accept, access;
  logic        acc_we, acc_err;
  logic [29:0] acc_idx;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        rd_hit, err_q;
  logic [31:0] arr_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access   = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if ({1'b0, cnt} + 5'd1 == 5'(WAIT_CYCLES)) begin
          access   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Zero-wait accesses happen on the accept edge, so operands come straight from the request.
  assign acc_we    = (state == IDLE) ? req_we         : lat_we;
  assign acc_idx   = (state == IDLE) ? req_addr[31:2] : lat_idx;
  assign acc_wdata = (state == IDLE) ? req_wdata      : lat_wdata;
  assign acc_be    = (state == IDLE) ? req_be         : lat_be;
  assign acc_err   = {2'b00, acc_idx} >= 32'(DEPTH_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rd_hit    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt       <= '0;
        lat_we    <= req_we;
        lat_idx   <= req_addr[31:2];
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (access) begin
        rd_hit <= !acc_we && !acc_err;
        err_q  <= acc_err;
      end
    end
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (access && !acc_err) begin
      if (acc_we) wr_count <= wr_count + 1'b1;
      else        rd_count <= rd_count + 1'b1;
    end
  end
`endif

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (access && acc_we && !acc_err),
    .be    (acc_be),
    .waddr (acc_idx[AW-1:0]),
    .wdata (acc_wdata),
    .re    (access && !acc_we && !acc_err),
    .raddr (acc_idx[AW-1:0]),
    .rdata (arr_rdata)
  );

  // Read data is only meaningful after a good load; stores and errors return zero.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rd_hit ? arr_rdata : 32'h0;
  assign rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port: accepts one load/store request at a time over a valid/ready handshake and performs the word access with per-byte write enables. It waits a programmable number of cycles, then returns read data plus an error flag over a second handshake. It sits behind the MEM stage, which generates byte enables and extracts sub-word load data. This block only stores and returns full 32-bit words.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two ≥ 4.
- `WAIT_CYCLES`, 1: extra cycles between acceptance and access; 0..15.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; `[1:0]` ignored.
- `req_wdata`  in  32  store data, lane-aligned.
- `req_be`  in  4  byte-lane write enables, used only when `req_we`=1.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes response.
- `rsp_rdata`  out  32  word read; 0 for stores and errors.
- `rsp_err`  out  1  address out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch we/addr/wdata/be and reset the wait counter.
  - Go to WAIT if `WAIT_CYCLES`>0, otherwise perform the access on the same edge and go to RESP.
- WAIT:
  - The counter increments each cycle.
  - On the edge where the count reaches `WAIT_CYCLES`, perform the access and go to RESP.
  - Inputs on the request channel are ignored during WAIT.
- Access:
  - Word index = latched `addr[31:2]`.
  - Error if index ≥ `DEPTH_WORDS` (full 30-bit compare; no wrap). On error there is no array write, `rsp_rdata`=0 and `rsp_err`=1.
  - Store: lane i is written iff `be[i]`; `be`=0 is a legal no-op store with no error.
  - Load: capture the whole word.
- RESP:
  - `rsp_valid`=1 and outputs are stable until `rsp_valid && rsp_ready`; then go to IDLE.
  - `req_ready`=0 while in RESP. A new request cannot be accepted in the same cycle as the response handshake.
- Array contents are not initialised by reset.

## Timing
- Reset values:
  - `req_ready`=1 (its value is combinational from state IDLE).
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - State IDLE, counter 0.
- Latency: with acceptance at edge E, the access happens at edge E+`WAIT_CYCLES`. `rsp_valid` is high from the cycle after that edge.
- Minimum request spacing: `WAIT_CYCLES`+2 cycles, with `rsp_ready` tied high.
- Store visibility: a load accepted after a store's response handshake returns the stored data.
- Backpressure: holding `rsp_ready` low keeps RESP indefinitely; response data must not change.
- Reset mid-operation:
  - Return to IDLE immediately and deassert `rsp_valid`.
  - A store not yet accessed is dropped. A store already accessed remains in the array.
- `req_ready` and `rsp_valid` are mutually exclusive.

## Configuration
- `DMEM_PERF_CNT_EN` defined:
  - Adds outputs `rd_count` [31:0] and `wr_count` [31:0].
  - Each increments on the access edge of a non-error load or store respectively, wrapping at 2^32.
  - Both reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - `DMEM_WAIT_W`=4 counter width;
  - default depth constant.
- Sub-module `dmem_array`: `DEPTH_WORDS`×32 storage with 4 byte-lane write enables, one synchronous write port and one synchronous read port. FSM and counter stay in `dmem_responder`.

## Test plan
- Reset, then store addr 0x10, wdata 0xDEADBEEF, be 4'b1111, then load 0x10 -> `rsp_rdata`=0xDEADBEEF, `rsp_err`=0. `rsp_valid` rises exactly `WAIT_CYCLES`+1 cycles after each acceptance cycle.
- Store 0x20=0x11223344, then store 0x22 wdata 0xAABB0000 be 4'b1100, load 0x20 -> 0xAABB3344.
- `DEPTH_WORDS`=1024: load addr 0x1000 -> `rsp_err`=1, `rsp_rdata`=0. Store 0x1000 then load 0x0 -> word 0 unchanged.
- Hold `rsp_ready`=0 for 10 cycles after a load -> `rsp_valid` stays high and `rsp_rdata` is stable. `req_ready`=0 throughout, and a `req_valid` pulse in that window is not accepted.
- Assert `rst`=0 during WAIT of a store to 0x30 (prior content 0x0) -> `rsp_valid`=0 immediately. After release, load 0x30 returns 0x0.
- With `DMEM_PERF_CNT_EN`: 3 good loads, 2 good stores and 1 error load -> `rd_count`=3, `wr_count`=2.
